// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch slice.
//   fetch_state_t : FSM encoding used by fetch_unit
//   INSTR_BYTES   : byte distance between consecutive instruction words
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_FLUSH = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch stage's non-clock signals.
//   Control in : stall_i, branchEnable_i, branchAddress_i (from decode/execute)
//   Memory     : memReq_o/memAddress_o out, memAck_i/memData_i in
//   Decode out : enable_o, instruction_o, instructionAddress_o
// master = fetch unit side, slave = the surrounding pipeline/memory.
interface fetch_if #(
  parameter int unsigned instructionWidth = 32,
  parameter int unsigned addressSize      = 64
);

  logic                          stall_i;
  logic                          branchEnable_i;
  logic [0:addressSize-1]        branchAddress_i;
  logic                          memReq_o;
  logic [0:addressSize-1]        memAddress_o;
  logic                          memAck_i;
  logic [0:instructionWidth-1]   memData_i;
  logic                          enable_o;
  logic [0:instructionWidth-1]   instruction_o;
  logic [0:addressSize-1]        instructionAddress_o;

  modport master (
    input  stall_i, branchEnable_i, branchAddress_i, memAck_i, memData_i,
    output memReq_o, memAddress_o, enable_o, instruction_o, instructionAddress_o
  );

  modport slave (
    output stall_i, branchEnable_i, branchAddress_i, memAck_i, memData_i,
    input  memReq_o, memAddress_o, enable_o, instruction_o, instructionAddress_o
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {instruction, address} entries.
//   clock_i, reset_i : clock, asynchronous active-high reset
//   push_i, data_i   : write one entry
//   pop_i, data_o    : data_o shows the oldest entry; pop_i consumes it
//   flush_i          : discard all entries (wins over push/pop)
//   full_o, empty_o, count_o : occupancy status
// depth must be a power of two (>= 2) so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned width = 96,
  parameter int unsigned depth = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [width-1:0]           data_i,
  output logic [width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(depth):0]     count_o
);

  localparam int unsigned ptrBits = $clog2(depth);

  logic [width-1:0]   store [depth];
  logic [ptrBits-1:0] rdPtr;
  logic [ptrBits-1:0] wrPtr;
  logic [ptrBits:0]   count;
  logic               doPush;
  logic               doPop;

  assign full_o  = (count == (ptrBits + 1)'(depth));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = store[rdPtr];

  assign doPush = push_i && !flush_i && !full_o;
  assign doPop  = pop_i  && !flush_i && !empty_o;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ptrBits'(1);
      if (doPop)  rdPtr <= rdPtr + ptrBits'(1);
      count <= count + (ptrBits + 1)'(doPush) - (ptrBits + 1)'(doPop);
    end
  end

  // Storage needs no reset: empty_o/count gate every read.
  always_ff @(posedge clock_i) begin
    if (doPush) store[wrPtr] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decode unit.
//   clock_i  : clock, all state updates on posedge
//   reset_i  : asynchronous active-high reset
//   bus      : fetch_if.master
//     stall_i          decode cannot accept; output registers hold
//     branchEnable_i   one-cycle redirect request (overrides stall_i)
//     branchAddress_i  redirect target, two low bits forced to zero
//     memReq_o/memAddress_o, memAck_i/memData_i   single-outstanding read
//     enable_o/instruction_o/instructionAddress_o to decode
// Holds the PC, issues one word read at a time, buffers returned words in
// fetch_fifo and presents them one per cycle from a registered output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned            instructionWidth = 32,
  parameter int unsigned            addressSize      = 64,
  parameter logic [0:addressSize-1] resetVector      = '0,
  parameter int unsigned            fifoDepth        = 4
) (
  input logic     clock_i,
  input logic     reset_i,
  fetch_if.master bus
);

  localparam int unsigned entryWidth = instructionWidth + addressSize;
  localparam int unsigned countBits  = $clog2(fifoDepth) + 1;
  localparam logic [0:addressSize-1] alignMask = {{(addressSize - 2){1'b1}}, 2'b00};

  fetch_state_t                state;
  fetch_state_t                stateNext;
  logic [0:addressSize-1]      pc;
  logic [0:addressSize-1]      flushAddress;
  logic [0:addressSize-1]      branchTarget;
  logic                        push;
  logic                        pop;
  logic                        fifoFull;
  logic                        fifoEmpty;
  logic [countBits-1:0]        fifoCount;
  logic [countBits-1:0]        countAfter;
  logic [entryWidth-1:0]       fifoIn;
  logic [entryWidth-1:0]       fifoOut;
  logic                        memReq;
  logic [0:addressSize-1]      memAddress;
  logic                        enable;
  logic [0:instructionWidth-1] instruction;
  logic [0:addressSize-1]      instructionAddress;

  assign branchTarget = bus.branchAddress_i & alignMask;

  // A redirect cancels the push of a word acked in the same cycle.
  assign push   = (state == FETCH_REQ) && bus.memAck_i && !bus.branchEnable_i;
  assign pop    = !bus.branchEnable_i && !bus.stall_i && !fifoEmpty;
  assign fifoIn = {bus.memData_i, pc};

  // Occupancy after this edge, used to decide whether another request fits.
  assign countAfter = fifoCount + countBits'(push) - countBits'(pop);

  fetch_fifo #(
    .width (entryWidth),
    .depth (fifoDepth)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.branchEnable_i),
    .data_i  (fifoIn),
    .data_o  (fifoOut),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= FETCH_IDLE;
    else         state <= stateNext;
  end

  // Request outputs are decoded from the state register only, so reset
  // drops memReq_o/memAddress_o asynchronously and no memory input reaches
  // them combinationally.
  always_comb begin
    stateNext  = state;
    memReq     = 1'b0;
    memAddress = '0;
    unique case (state)
      FETCH_IDLE: begin
        if (bus.branchEnable_i || !fifoFull) stateNext = FETCH_REQ;
      end
      FETCH_REQ: begin
        memReq     = 1'b1;
        memAddress = pc;
        if (bus.branchEnable_i) begin
          stateNext = bus.memAck_i ? FETCH_REQ : FETCH_FLUSH;
        end else if (bus.memAck_i) begin
          stateNext = (countAfter < countBits'(fifoDepth)) ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_FLUSH: begin
        // Old request stays on the bus until memory completes it.
        memReq     = 1'b1;
        memAddress = flushAddress;
        if (!bus.branchEnable_i && bus.memAck_i) stateNext = FETCH_REQ;
      end
      default: stateNext = FETCH_IDLE;
    endcase
  end

  // pc already holds the redirect target while FLUSH waits, so the
  // abandoned address is kept separately for the bus.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pc           <= resetVector;
      flushAddress <= '0;
    end else if (bus.branchEnable_i) begin
      pc <= branchTarget;
      if ((state == FETCH_REQ) && !bus.memAck_i) flushAddress <= pc;
    end else if (push) begin
      pc <= pc + addressSize'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      enable             <= 1'b0;
      instruction        <= '0;
      instructionAddress <= '0;
    end else if (bus.branchEnable_i) begin
      enable <= 1'b0;
    end else if (bus.stall_i) begin
      enable <= enable;
    end else if (!fifoEmpty) begin
      enable             <= 1'b1;
      instruction        <= fifoOut[addressSize +: instructionWidth];
      instructionAddress <= fifoOut[0 +: addressSize];
    end else begin
      enable <= 1'b0;
    end
  end

  assign bus.memReq_o             = memReq;
  assign bus.memAddress_o         = memAddress;
  assign bus.enable_o             = enable;
  assign bus.instruction_o        = instruction;
  assign bus.instructionAddress_o = instructionAddress;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [63:0] RV = 64'hFFFF_FFFF_FFFF_FFF8;

  logic clock_i = 1'b0;
  logic reset_i;

  always #5 clock_i = ~clock_i;

  fetch_if #(.instructionWidth(32), .addressSize(64)) bus ();

  fetch_unit #(
    .instructionWidth (32),
    .addressSize      (64),
    .resetVector      (RV),
    .fifoDepth        (4)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // Program-order model: the addresses decode must see, in order.
  logic [63:0] expQ[$];
  logic [63:0] nextAddr;
  int          latMode = 0;   // -1: random 0..3 wait cycles, else fixed

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void refill();
    while (expQ.size() < 8) begin
      expQ.push_back(nextAddr);
      nextAddr = nextAddr + 64'd4;
    end
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: decides at negedge whether the next edge acks.
  int waitCnt = 0;
  int lat     = 0;
  always @(negedge clock_i) begin
    if (reset_i || !bus.memReq_o) begin
      bus.memAck_i = 1'b0;
      waitCnt      = 0;
    end else if (waitCnt >= lat) begin
      bus.memAck_i  = 1'b1;
      bus.memData_i = word_at(bus.memAddress_o);
      waitCnt       = 0;
      lat           = (latMode < 0) ? int'($urandom_range(0, 3)) : latMode;
    end else begin
      bus.memAck_i = 1'b0;
      waitCnt++;
    end
  end

  // Monitor: samples 1 ns after each edge, when the inputs still hold the
  // values that edge used.
  bit          pValid = 0;
  logic        pEn;
  logic        pReq;
  logic [31:0] pIns;
  logic [63:0] pIa;
  logic [63:0] pMa;
  logic [63:0] mExp;
  logic [63:0] mAddr;
  always begin
    @(posedge clock_i);
    #1;
    if (reset_i) begin
      pValid = 0;
    end else begin
      if (bus.branchEnable_i) begin
        check_eq("redirect_enable", bus.enable_o, 0);
        expQ.delete();
        nextAddr = bus.branchAddress_i & ~64'h3;
        refill();
      end else if (bus.stall_i) begin
        if (pValid) begin
          check_eq("stall_hold_enable", bus.enable_o, pEn);
          check_eq("stall_hold_instr", bus.instruction_o, pIns);
          check_eq("stall_hold_addr", bus.instructionAddress_o, pIa);
        end
      end else if (bus.enable_o) begin
        refill();
        mExp = expQ.pop_front();
        check_eq("deliver_addr", bus.instructionAddress_o, mExp);
        check_eq("deliver_data", bus.instruction_o, word_at(mExp));
      end
      mAddr = bus.memAddress_o;
      if (pValid && pReq && !bus.memAck_i && bus.memReq_o)
        check_eq("req_addr_stable", mAddr, pMa);
      if (bus.memReq_o)
        check_eq("req_addr_aligned", mAddr[1:0], 0);
      pEn    = bus.enable_o;
      pIns   = bus.instruction_o;
      pIa    = bus.instructionAddress_o;
      pReq   = bus.memReq_o;
      pMa    = mAddr;
      pValid = 1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock_i);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish, %0d tests, %0d failed so far", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   timedOut;
    bit   prevHigh;
    bit   consec;

    bus.stall_i         = 1'b0;
    bus.branchEnable_i  = 1'b0;
    bus.branchAddress_i = '0;
    reset_i             = 1'b1;
    expQ.delete();
    nextAddr = RV;
    refill();

    // Reset state
    repeat (2) @(posedge clock_i);
    #1;
    check_eq("rst_memReq", bus.memReq_o, 0);
    check_eq("rst_memAddress", bus.memAddress_o, 0);
    check_eq("rst_enable", bus.enable_o, 0);
    check_eq("rst_instruction", bus.instruction_o, 0);
    check_eq("rst_instrAddress", bus.instructionAddress_o, 0);
    #1;
    reset_i = 1'b0;

    // Zero-wait memory: first-word latency, then no gaps
    timedOut = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock_i);
      #1;
      if (bus.memAck_i) begin
        timedOut = 0;
        break;
      end
    end
    check_eq("first_ack_timeout", timedOut, 0);
    check_eq("ack_edge_enable", bus.enable_o, 0);
    @(posedge clock_i);
    #1;
    check_eq("first_enable", bus.enable_o, 1);
    check_eq("first_address", bus.instructionAddress_o, RV);
    n = 0;
    repeat (20) begin
      @(posedge clock_i);
      #1;
      if (bus.enable_o) n++;
    end
    check_eq("no_gap_count", n, 20);
    #1;

    // Three wait cycles per request: one enable pulse per word
    latMode = 3;
    cycles(12);
    n = 0;
    prevHigh = 0;
    consec = 0;
    repeat (32) begin
      @(posedge clock_i);
      #1;
      if (bus.enable_o) begin
        n++;
        if (prevHigh) consec = 1;
      end
      prevHigh = bus.enable_o;
    end
    check_eq("slow_pulse_count", n, 8);
    check_eq("slow_consecutive", consec, 0);
    #1;

    // Long stall with zero-wait memory: fetch must stop
    latMode = 0;
    cycles(5);
    bus.stall_i = 1'b1;
    cycles(9);
    @(posedge clock_i);
    #1;
    check_eq("stall_idle_memReq", bus.memReq_o, 0);
    #1;
    bus.stall_i = 1'b0;
    cycles(20);

    // Redirect while a slow request is outstanding
    latMode = 3;
    cycles(1);
    bus.branchEnable_i  = 1'b1;
    bus.branchAddress_i = 64'h10;
    cycles(1);
    bus.branchEnable_i  = 1'b0;
    timedOut = 1;
    for (int i = 0; i < 40; i++) begin
      if (bus.memReq_o && bus.memAddress_o == 64'h10) begin
        timedOut = 0;
        break;
      end
      cycles(1);
    end
    check_eq("req_0x10_timeout", timedOut, 0);
    bus.branchEnable_i  = 1'b1;
    bus.branchAddress_i = 64'h1003;
    @(posedge clock_i);
    #1;
    check_eq("flush_memReq", bus.memReq_o, 1);
    check_eq("flush_old_address", bus.memAddress_o, 64'h10);
    #1;
    bus.branchEnable_i = 1'b0;
    timedOut = 1;
    for (int i = 0; i < 40; i++) begin
      if (bus.memReq_o && bus.memAddress_o != 64'h10) begin
        timedOut = 0;
        break;
      end
      cycles(1);
    end
    check_eq("post_flush_timeout", timedOut, 0);
    check_eq("post_flush_address", bus.memAddress_o, 64'h1000);
    cycles(30);

    // Redirect in the same cycle as a stall, FIFO holding words
    latMode = 0;
    cycles(5);
    bus.stall_i = 1'b1;
    cycles(6);
    bus.branchEnable_i  = 1'b1;
    bus.branchAddress_i = 64'h0000_1234_5678_9AB5;
    cycles(1);
    bus.branchEnable_i = 1'b0;
    cycles(2);
    bus.stall_i = 1'b0;
    cycles(20);

    // Randomised traffic
    latMode = -1;
    repeat (1500) begin
      bus.stall_i        = ($urandom_range(0, 99) < 30);
      bus.branchEnable_i = ($urandom_range(0, 99) < 4);
      if (bus.branchEnable_i) bus.branchAddress_i = {$urandom, $urandom};
      cycles(1);
    end
    bus.stall_i        = 1'b0;
    bus.branchEnable_i = 1'b0;
    cycles(20);

    // Reset asserted while a request waits, then wrap from the reset vector
    latMode = 3;
    cycles(4);
    timedOut = 1;
    for (int i = 0; i < 20; i++) begin
      if (bus.memReq_o) begin
        timedOut = 0;
        break;
      end
      cycles(1);
    end
    check_eq("wait_req_timeout", timedOut, 0);
    #1;
    reset_i = 1'b1;
    #1;
    check_eq("async_rst_memReq", bus.memReq_o, 0);
    check_eq("async_rst_memAddress", bus.memAddress_o, 0);
    check_eq("async_rst_enable", bus.enable_o, 0);
    expQ.delete();
    nextAddr = RV;
    refill();
    latMode = 0;
    cycles(2);
    reset_i = 1'b0;
    cycles(25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Sits directly upstream of the decode unit and drives its enable_i, instruction_i and instructionAddress_i inputs.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake, with at most one read outstanding.
- Buffers returned words in a small FIFO. Presents them one per cycle to decode, honouring a downstream stall and a branch redirect.

Parameters:
- instructionWidth, 32, instruction word width.
- addressSize, 64, PC/byte-address width.
- resetVector, 64'h0000_0000_0000_0000, PC loaded on reset.
- fifoDepth, 4, buffered instruction entries; power of two, at least 2.

Ports:
- clock_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  decode cannot accept; output registers hold.
- branchEnable_i  in  1  redirect request, valid for one cycle.
- branchAddress_i  in  [0:addressSize-1]  redirect target; bits [62:63] ignored (forced 0).
- memReq_o  out  1  read request to instruction memory.
- memAddress_o  out  [0:addressSize-1]  word-aligned read address.
- memAck_i  in  1  memory returns data this cycle.
- memData_i  in  [0:instructionWidth-1]  instruction word, valid with memAck_i.
- enable_o  out  1  instruction_o/instructionAddress_o valid (to decode enable_i).
- instruction_o  out  [0:instructionWidth-1]  fetched instruction.
- instructionAddress_o  out  [0:addressSize-1]  address of instruction_o.

Behaviour:
- Reset (async): pc=resetVector, FIFO empty, state=IDLE.
- All outputs are 0 during reset: memReq_o, memAddress_o, enable_o, instruction_o, instructionAddress_o.
- States:
  - IDLE: memReq_o=0. Go to REQ when FIFO free slots ≥1.
  - REQ: memReq_o=1, memAddress_o=pc.
    - Address and request stay stable until memAck_i.
    - On memAck_i: push {memData_i, pc}; pc+=4.
    - Next state is REQ again if free slots after this push are ≥1, else IDLE.
  - FLUSH: entered when a redirect arrives while in REQ without a same-cycle ack.
    - memReq_o stays 1 with the old address.
    - On memAck_i: discard the data and go to REQ at the new pc.
- Memory may ack in the same cycle as the request (zero-wait). Each acked request holds one entry.
- FIFO: circular, fifoDepth entries, separate read/write pointers plus a count.
  - Push and pop in the same cycle are legal at any occupancy except a push when full, which cannot occur by construction.
  - Pointers wrap modulo fifoDepth.
- Output register, at each edge, first matching rule wins:
  - Redirect: enable_o<=0.
  - stall_i=1: hold all three output registers.
  - FIFO non-empty: pop into instruction_o/instructionAddress_o; enable_o<=1.
  - Otherwise: enable_o<=0, data registers hold.
- Redirect (branchEnable_i=1 at an edge):
  - Flush the FIFO (count=0, pointers equal).
  - pc<=branchAddress_i with bits [62:63] cleared.
  - Cancel any same-cycle push.
  - If in REQ and no memAck_i this cycle: go to FLUSH. Else go to REQ.
  - A redirect during FLUSH only updates pc; the state stays FLUSH.
  - Redirect overrides stall_i.
- Latency: memAck_i at edge N → enable_o high from edge N+1 when the FIFO was empty and stall_i=0. There is no combinational path from mem inputs to outputs.
- PC wraps modulo 2^addressSize: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Reset asserted mid-request: the request is abandoned immediately and memReq_o drops asynchronously.

Decomposition:
- Shared package (fetch_pkg): state encodings FETCH_IDLE=2'd0, FETCH_REQ=2'd1, FETCH_FLUSH=2'd2; the constant INSTR_BYTES=4.
- Submodule fetch_fifo: parameterised circular buffer with push, pop, flush, full, empty and count. The top level contains the FSM, pc and output register.

Test Plan:
- Reset, then zero-wait memory (ack whenever memReq_o) with resetVector=0 → memAddress_o sequence 0,4,8,…; enable_o rises with instructionAddress_o=0, and data matches memory words in order with no gaps.
- Memory acks 3 cycles after each request → one request outstanding at a time, memAddress_o stable while waiting, enable_o pulses once per returned word.
- stall_i held high for 10 cycles with zero-wait memory → fetch halts after fifoDepth=4 buffered words plus the held output (memReq_o low in IDLE). After release, addresses continue consecutively with none lost or duplicated.
- branchEnable_i with branchAddress_i=64'h1003 while a slow request to 0x10 is outstanding → FLUSH; the 0x10 data is dropped; the next request is to 0x1000; the first enable_o carries 0x1000.
- Redirect in the same cycle as stall_i=1 with a non-empty FIFO → enable_o=0 next cycle; the FIFO is empty; the old-path addresses never appear.
- resetVector=64'hFFFF_FFFF_FFFF_FFF8 → fetch addresses …FFF8, …FFFC, 0, 4. Assert reset_i mid-wait → memReq_o and enable_o are 0 immediately.
